audio_sample_fifo: RTL

Memory-mapped audio streaming peripheral on the PicoSoC iomem bus. It occupies one 16 MB region, selected by iomem_addr[31:24] == BASE_ADDR.
- CPU writes 12-bit PCM samples into an internal FIFO.
- The block pops one sample per sample period and drives audio_out, which feeds the existing pdm_dac.
- This replaces direct single-register audio writes with rate-paced, buffered playback.

---
 rtl/audio_sample_fifo.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : audio_sample_fifo
//  Purpose  : iomem-mapped audio playback peripheral. The CPU pushes 12-bit
//             PCM samples into an internal FIFO. One sample is popped per
//             sample period and held on audio_out, which feeds pdm_dac.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1   system clock
//    resetn         in   1   synchronous, active-low reset
//    iomem_valid    in   1   bus request valid
//    iomem_ready    out  1   one-cycle acknowledge
//    iomem_wstrb    in   4   byte write strobes, 0 = read
//    iomem_addr     in  32   bus address, [31:24] selects the block
//    iomem_wdata    in  32   write data
//    iomem_rdata    out 32   read data, valid while iomem_ready=1
//    audio_out      out 12   current sample to the DAC
//    sample_strobe  out  1   one-cycle pulse per sample tick
//    irq_low        out  1   enabled and FIFO below half full
// ----------------------------------------------------------------------------
//  Register map (iomem_addr[7:0])
//    0x00 DATA   W: push wdata[11:0]            R: level
//    0x04 STATUS R: {level, ovf, und, full, empty}  W: 1 clears und/ovf
//    0x08 CTRL   R/W: bit0 enable, W bit1 flush (self-clearing)
// ============================================================================
module audio_sample_fifo #(
    parameter logic [7:0] BASE_ADDR  = 8'h04,
    parameter int         CLK_HZ     = 16000000,
    parameter int         SAMPLE_HZ  = 8000,
    parameter int         DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [11:0] audio_out,
    output logic        sample_strobe,
    output logic        irq_low
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_div   = CLK_HZ / SAMPLE_HZ;
    localparam int c_div_w = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_depth = 1 << DEPTH_LOG2;

    localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(c_div - 1);
    localparam logic [DEPTH_LOG2:0] c_level_full = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] c_level_half = c_level_full >> 1;

    localparam logic [7:0] c_off_data   = 8'h00;
    localparam logic [7:0] c_off_status = 8'h04;
    localparam logic [7:0] c_off_ctrl   = 8'h08;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [11:0]           r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_enable;
    logic                  r_underrun;
    logic                  r_overflow;
    logic [c_div_w-1:0]    r_div;

    // ------------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------------
    logic       w_take;
    logic       w_write;
    logic       w_read;
    logic [7:0] w_off;

    // The !iomem_ready term stops a still-asserted valid during the ack cycle
    // from being taken as a second access.
    assign w_take  = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign w_write = w_take && (iomem_wstrb != 4'b0000);
    assign w_read  = w_take && (iomem_wstrb == 4'b0000);
    assign w_off   = iomem_addr[7:0];

    // Address bits [23:8] and data bits above the sample are don't-care.
    logic w_unused;
    assign w_unused = ^{iomem_addr[23:8], iomem_wdata[31:12]};

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    logic w_empty;
    logic w_full;
    logic w_tick;
    logic w_flush;
    logic w_push_req;
    logic w_push;
    logic w_pop;
    logic w_ovf_set;
    logic w_und_set;
    logic w_ovf_clr;
    logic w_und_clr;
    logic w_enable_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_level_full);
    assign w_tick  = r_enable && (r_div == c_div_last);

    assign w_flush    = w_write && (w_off == c_off_ctrl) && iomem_wdata[1];
    assign w_push_req = w_write && (w_off == c_off_data);

    // Fullness is judged on the level at the access cycle, so a push into a
    // full FIFO is lost even when a pop frees a slot on the same edge.
    assign w_push = w_push_req && !w_full && !w_flush;

    // Emptiness is also judged before the push, so a push into an empty FIFO
    // on a tick cycle is an underrun and the new sample stays queued.
    assign w_pop  = w_tick && !w_empty && !w_flush;

    assign w_ovf_set = w_push_req && w_full;
    assign w_und_set = w_tick && w_empty;
    assign w_ovf_clr = w_write && (w_off == c_off_status) && iomem_wdata[3];
    assign w_und_clr = w_write && (w_off == c_off_status) && iomem_wdata[2];

    assign w_enable_nxt = (w_write && (w_off == c_off_ctrl)) ? iomem_wdata[0] : r_enable;

    logic [DEPTH_LOG2:0] w_level_nxt;

    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Read mux (uses the state as it is during the access cycle)
    // ------------------------------------------------------------------------
    logic [31:0] w_rdata;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_off_data: begin
                w_rdata[DEPTH_LOG2:0] = r_level;
            end
            c_off_status: begin
                w_rdata[0]                = w_empty;
                w_rdata[1]                = w_full;
                w_rdata[2]                = r_underrun;
                w_rdata[3]                = r_overflow;
                w_rdata[8 +: DEPTH_LOG2+1] = r_level;
            end
            c_off_ctrl: begin
                w_rdata[0] = r_enable;
            end
            default: begin
                w_rdata = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sample storage: contents need no reset, the pointers define validity.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iomem_wdata[11:0];
        end
    end

    // ------------------------------------------------------------------------
    // Control, pointers, divider and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready   <= 1'b0;
            iomem_rdata   <= '0;
            audio_out     <= 12'h800;
            sample_strobe <= 1'b0;
            irq_low       <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_enable      <= 1'b0;
            r_underrun    <= 1'b0;
            r_overflow    <= 1'b0;
            r_div         <= '0;
        end else begin
            iomem_ready   <= w_take;
            iomem_rdata   <= w_read ? w_rdata : 32'h0;
            sample_strobe <= w_tick;

            if (w_pop) begin
                audio_out <= r_mem[r_rd_ptr];
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            r_level  <= w_level_nxt;
            r_enable <= w_enable_nxt;

            // Divider runs only while enabled and restarts from 0 otherwise,
            // so the first tick lands a full period after enabling.
            if (!r_enable || (r_div == c_div_last)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            // A new event in the same cycle as a clear keeps the flag set.
            if (w_und_set) begin
                r_underrun <= 1'b1;
            end else if (w_und_clr) begin
                r_underrun <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            // Built from next-state values so the level output always matches
            // the ENABLE and level registers visible in the same cycle.
            irq_low <= w_enable_nxt && (w_level_nxt < c_level_half);
        end
    end

endmodule
`default_nettype wire
